// File: rtl/bitonic_sort_engine_pkg.sv
// Shared types and helpers for the iterative bitonic sorter.
package sort_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SORT = ST_SORT,
        DONE = ST_DONE
    } state_t;

    function automatic int nsub(input int log2n);
        return log2n * (log2n + 1) / 2;
    endfunction

    // Direction of the pair whose lower index is i in stage s (block size 2**s).
    function automatic logic key_dir(input int i, input int s, input logic desc);
        return ((((i >> s) & 1) != 0) ? 1'b1 : 1'b0) ^ desc;
    endfunction

endpackage

// File: rtl/bitonic_sort_engine_cmp_swap.sv
// Pair compare-exchange: lo_hi[WIDTH-1:0] lands at the lower index, the upper half at the higher index.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               dir,
    output logic [2*WIDTH-1:0] lo_hi
);

    logic swap;

    // Equal keys never swap, so ties stay put in either direction.
    assign swap  = dir ? (a < b) : (a > b);
    assign lo_hi = swap ? {a, b} : {b, a};

endmodule

// File: rtl/bitonic_sort_engine.sv
// Iterative bitonic sorter: one sub-stage of N/2 compare-exchanges per clock, valid/ready load and unload.
module bitonic_sort_engine
    import sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2N = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       descend,
    input  logic [(2**LOG2N)*WIDTH-1:0] data_in,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(2**LOG2N)*WIDTH-1:0] data_out,
    output logic                       busy,
    output logic                       done
);

    localparam int N    = 2**LOG2N;
    localparam int DW   = N * WIDTH;
    localparam int NP   = N / 2;

    state_t          state;
    logic [DW-1:0]   arr;
    logic [DW-1:0]   arr_nxt;
    logic            desc_q;
    logic [2:0]      s;
    logic [2:0]      t;

    logic [LOG2N-1:0]   lo_idx [NP];
    logic [LOG2N-1:0]   hi_idx [NP];
    logic [WIDTH-1:0]   pa     [NP];
    logic [WIDTH-1:0]   pb     [NP];
    logic               pdir   [NP];
    logic [2*WIDTH-1:0] pout   [NP];

    // Pair p gets lower index = p with a zero inserted at bit t; partner differs only in bit t.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            lo_idx[p] = LOG2N'(((p >> t) << (t + 3'd1)) | (p & ((1 << t) - 1)));
            hi_idx[p] = lo_idx[p] | LOG2N'(1 << t);
            pdir[p]   = key_dir(int'(lo_idx[p]), int'(s), desc_q);
            pa[p]     = arr[int'(lo_idx[p]) * WIDTH +: WIDTH];
            pb[p]     = arr[int'(hi_idx[p]) * WIDTH +: WIDTH];
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_cs
        cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
            .a     (pa[p]),
            .b     (pb[p]),
            .dir   (pdir[p]),
            .lo_hi (pout[p])
        );
    end

    always_comb begin
        arr_nxt = arr;
        for (int p = 0; p < NP; p++) begin
            arr_nxt[int'(lo_idx[p]) * WIDTH +: WIDTH] = pout[p][WIDTH-1:0];
            arr_nxt[int'(hi_idx[p]) * WIDTH +: WIDTH] = pout[p][2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            arr    <= '0;
            desc_q <= 1'b0;
            s      <= '0;
            t      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        arr    <= data_in;
                        desc_q <= descend;
                        s      <= 3'd1;
                        t      <= 3'd0;
                        state  <= SORT;
                    end
                end
                SORT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        arr <= arr_nxt;
                        if (t != 3'd0) begin
                            t <= t - 3'd1;
                        end else if (s < 3'(LOG2N)) begin
                            s <= s + 3'd1;
                            t <= s;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SORT);
    assign out_valid = (state == DONE);
    assign data_out  = arr;

endmodule

// File: tb/tb_bitonic_sort_engine.sv
// Directed and randomized checks of bitonic_sort_engine against a queue-sort reference.
module tb_bitonic_sort_engine;

    localparam int WIDTH = 8;
    localparam int LOG2N = 4;
    localparam int N     = 2**LOG2N;
    localparam int DW    = N * WIDTH;
    localparam int NSUB  = LOG2N * (LOG2N + 1) / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          descend = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    bitonic_sort_engine #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .descend   (descend),
        .data_in   (data_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_sort(input logic [DW-1:0] d, input bit desc);
        int q[$];
        logic [DW-1:0] r;
        for (int m = 0; m < N; m++) q.push_back(int'(d[m*WIDTH +: WIDTH]));
        if (desc) q.rsort();
        else q.sort();
        r = '0;
        for (int m = 0; m < N; m++) r[m*WIDTH +: WIDTH] = WIDTH'(q[m]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_keys();
        logic [DW-1:0] r;
        for (int m = 0; m < N; m++) r[m*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, DW'(in_ready), DW'(1));
        check({tag, " out_valid"}, DW'(out_valid), DW'(0));
        check({tag, " busy"}, DW'(busy), DW'(0));
        check({tag, " done"}, DW'(done), DW'(0));
        check({tag, " data_out"}, data_out, '0);
    endtask

    // Offer a job and take the accept edge; leaves sampling point #1 after that edge.
    task automatic accept_job(input logic [DW-1:0] keys, input logic desc, input string tag);
        @(negedge clk);
        data_in  = keys;
        descend  = desc;
        in_valid = 1'b1;
        check({tag, " in_ready at offer"}, DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = rand_keys();
        descend  = ~desc;
        check({tag, " busy after accept"}, DW'(busy), DW'(1));
    endtask

    // Run a job to out_valid; if out_ready is high, also checks the drain edge.
    task automatic run_job(input logic [DW-1:0] keys, input logic desc, input string tag);
        int lat;
        int dones;
        logic [DW-1:0] exp;
        exp   = ref_sort(keys, desc);
        accept_job(keys, desc, tag);
        lat   = 0;
        dones = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) dones++;
        end
        check({tag, " latency"}, DW'(lat), DW'(NSUB));
        check({tag, " sorted"}, data_out, exp);
        check({tag, " done pulses"}, DW'(dones), DW'(1));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " idle after drain"}, DW'(in_ready), DW'(1));
            check({tag, " done cleared"}, DW'(done), DW'(0));
        end
    endtask

    int k1[N] = '{9, 5, 2, 3, 1, 6, 7, 0, 8, 10, 12, 11, 13, 15, 14, 4};
    int kd[4] = '{255, 0, 7, 7};

    initial begin
        logic [DW-1:0] keys;
        logic [DW-1:0] held;
        logic [DW-1:0] asc;
        int dones;

        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int m = 0; m < N; m++) keys[m*WIDTH +: WIDTH] = WIDTH'(k1[m]);
        for (int m = 0; m < N; m++) asc[m*WIDTH +: WIDTH] = WIDTH'(m);
        run_job(keys, 1'b0, "asc");
        check("asc literal 0..15", data_out, asc);
        run_job(keys, 1'b1, "desc");

        for (int m = 0; m < N; m++) keys[m*WIDTH +: WIDTH] = WIDTH'(kd[m % 4]);
        run_job(keys, 1'b0, "dup");

        // Backpressure: hold the result for 20 cycles while poking in_valid.
        out_ready = 1'b0;
        keys = rand_keys();
        run_job(keys, 1'b0, "bp");
        held = data_out;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = c[0];
            data_in  = rand_keys();
            @(posedge clk);
            #1;
            check("bp data stable", data_out, held);
            check("bp out_valid held", DW'(out_valid), DW'(1));
            check("bp in_ready low", DW'(in_ready), DW'(0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp idle after release", DW'(in_ready), DW'(1));
        check("bp out_valid drop", DW'(out_valid), DW'(0));
        run_job(rand_keys(), 1'b1, "post bp");

        // Abort raised during cycle A+4.
        accept_job(rand_keys(), 1'b0, "abort");
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        if (done) dones++;
        abort = 1'b0;
        check("abort in_ready", DW'(in_ready), DW'(1));
        check("abort busy", DW'(busy), DW'(0));
        check("abort out_valid", DW'(out_valid), DW'(0));
        check("abort no done", DW'(dones), DW'(0));
        run_job(rand_keys(), 1'b0, "post abort");

        // Asynchronous reset between clock edges mid-sort.
        accept_job(rand_keys(), 1'b1, "rst");
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst mid-sort");
        @(negedge clk);
        rst = 1'b1;
        run_job(rand_keys(), 1'b1, "post rst");

        for (int r = 0; r < 6; r++) begin
            run_job(rand_keys(), 1'($urandom_range(1, 0)), $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
